uart_rx_8n1: RTL and testbench
==============================

# uart_rx_8n1

Asynchronous serial receiver for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It samples the serial line once per bit at mid-bit, using a cycle counter clocked by the system clock. It presents each received byte as a one-cycle `valid` strobe, and flags bad stop bits with `frame_err`. It is the receiving end of the team's serial link, paired with the existing transmit side, and feeds byte-wide consumers in the same clock domain.

## Interface
- `CLKS_PER_BIT`, default 16: system clocks per serial bit. Must be an even integer ≥ 4.
- `clk` input 1: system clock. All logic is rising-edge triggered.
- `rst_n` input 1: reset, asynchronous and active-low.
- `rx` input 1: serial line, idle high. Asynchronous to `clk`.
- `data` output 8: last correctly framed byte.
- `valid` output 1: one-cycle strobe; `data` is new this cycle.
- `frame_err` output 1: one-cycle strobe; the stop bit was sampled low.
- `busy` output 1: high whenever the FSM is not in IDLE.

## Operation
- `rx` passes through a 2-flop synchronizer before any use. Both flops reset to 1. The result is called `rxs`.
- Reset values while `rst_n`=0, applied immediately:
  - `data`=8'h00, `valid`=0, `frame_err`=0, `busy`=0.
  - FSM=IDLE; counters=0.
- Reset mid-frame abandons the frame. The byte is not delivered and no strobe is asserted.
- Let H = CLKS_PER_BIT/2. Bit counter is 3 bits wide; cycle counter is ceil(log2(CLKS_PER_BIT)) bits wide.
- FSM states and transitions:
  - **IDLE**: on `rxs`=0 go to START and clear the cycle counter.
  - **START**: count H cycles, then sample `rxs`.
    - If 0: valid start bit. Go to DATA with bit index 0.
    - If 1: glitch. Return to IDLE with no strobe.
  - **DATA**: every CLKS_PER_BIT cycles, sample `rxs` into shift register position [bit index], LSB first. After bit 7, go to STOP.
  - **STOP**: after CLKS_PER_BIT cycles, sample `rxs`.
    - If 1: load `data` from the shift register, pulse `valid`, go to IDLE.
    - If 0: pulse `frame_err`, leave `data` unchanged, go to BREAK.
  - **BREAK**: wait until `rxs`=1, then go to IDLE. This prevents a held-low line from being read as back-to-back start bits.
- `valid` and `frame_err` are never high in the same cycle, and neither is ever high for more than 1 cycle.
- `busy`=1 in START, DATA, STOP and BREAK.
- A new frame whose start edge arrives right after the stop sample is accepted. The FSM is back in IDLE on the cycle after the stop sample, so back-to-back frames with exactly one stop bit are received without loss.

## Timing
- Let T0 be the first clock edge at which `rx`=0 is captured by the first sync flop.
  - `rxs` falls at T0+1.
  - FSM enters START at T0+2.
- Sample points, relative to START entry:
  - Start bit: cycle H.
  - Data bit k (k=0..7): cycle H+(k+1)·CLKS_PER_BIT.
  - Stop bit: cycle H+9·CLKS_PER_BIT.
- `valid` or `frame_err` is registered high in the cycle after the stop sample, i.e. START entry + H+9·CLKS_PER_BIT+1.
- `data` changes in the same cycle `valid` rises and holds until the next good frame.
- Tolerance: the sample point sits at mid-bit ±1 clock (±2 clocks including synchronizer skew). The required sender baud mismatch is ≤ ±4 % at CLKS_PER_BIT=16.

## Test plan
All scenarios use CLKS_PER_BIT=16 and a bit period of 16 clocks.
- **Reset:** drive `rst_n`=0 with `rx`=1 for 5 cycles, then release. Required: `data`=00, `valid`=0, `frame_err`=0, `busy`=0 throughout.
- **Single byte:** send 8'hA5 (line sequence 0,1,0,1,0,0,1,0,1,1). Required:
  - Exactly one `valid` pulse with `data`=A5.
  - The pulse lands 2+8+144+1=155 clocks after the start edge at the pin.
  - `busy` falls after the pulse.
- **Back-to-back frames:** send 8'h00, 8'hFF and 8'h3C with no idle between frames. Required: three `valid` pulses carrying 00, FF, 3C in order, no `frame_err`.
- **Framing error:** send 8'h55 with the stop bit held low, then hold `rx` low for 40 clocks, then release high. Required:
  - One `frame_err` pulse; `valid` stays 0; `data` keeps its prior value.
  - `busy` stays 1 until `rxs` returns high.
  - No spurious frame is started.
- **Glitch rejection:** pulse `rx` low for 4 clocks, then return high. Required: no strobe, and `busy` returns to 0 within H+3 cycles of the pulse.
- **Reset mid-frame:** assert `rst_n`=0 during data bit 4 of 8'h81, then release, then send 8'h7E. Required: no strobe for the aborted frame; exactly one `valid` with `data`=7E.

Source files
------------

// File: rtl/uart_rx_8n1_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_8n1_if
//  Description : Byte-side bundle for the 8N1 serial receiver. The master
//                view belongs to the receiver, which watches the serial line
//                and drives the byte, the strobes and busy. The slave view
//                belongs to whatever drives the line and consumes the bytes.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_8n1_if;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (
        input  rx,
        output data,
        output valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  data,
        input  valid,
        input  frame_err,
        input  busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_8n1.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_8n1
//  Description : 8N1 asynchronous serial receiver. It synchronises the line,
//                samples each bit once at mid-bit, and delivers each byte with
//                a one-cycle valid strobe. A bad stop bit gives a one-cycle
//                frame_err strobe instead.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_8n1 #(
    parameter int CLKS_PER_BIT = 16
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    uart_rx_8n1_if.master  bus
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    // The start bit is sampled at a count of H. After each sample the counter
    // restarts from 0, so a count of CLKS_PER_BIT-1 marks a full bit period.
    // This keeps CLKS_PER_BIT itself out of the counter range.
    localparam logic [CW-1:0] c_HALF = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] c_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic          r_sync1;
    logic          r_rxs;
    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_nxt;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_nxt;
    logic [7:0]    r_data;
    logic [7:0]    w_data_nxt;
    logic          r_valid;
    logic          w_valid_nxt;
    logic          r_ferr;
    logic          w_ferr_nxt;

    // Two-flop synchroniser for the asynchronous line. It resets to the idle
    // level so that reset itself cannot start a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_rxs   <= 1'b1;
        end else begin
            r_sync1 <= bus.rx;
            r_rxs   <= r_sync1;
        end
    end

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_ferr  <= w_ferr_nxt;
        end
    end

    // Next-state logic and bit sampling. The strobes default low, so each
    // one lasts exactly one cycle, and they come from different branches.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (!r_rxs) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (r_cnt == c_HALF) begin
                    w_cnt_nxt = '0;
                    if (!r_rxs) begin
                        w_state_nxt = S_DATA;
                        w_bit_nxt   = 3'd0;
                    end else begin
                        // The line went high again before mid-bit, so this
                        // was a glitch and not a start bit.
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (r_cnt == c_LAST) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_bit] = r_rxs;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = S_STOP;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (r_cnt == c_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_rxs) begin
                        w_data_nxt  = r_shift;
                        w_valid_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Wait here so that a line held low is not read as a train
                // of start bits.
                w_cnt_nxt = '0;
                if (r_rxs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign bus.data      = r_data;
    assign bus.valid     = r_valid;
    assign bus.frame_err = r_ferr;
    assign bus.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_8n1.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_8n1
//  Description : Directed bench for uart_rx_8n1 at 16 clocks per bit. Frames
//                are driven on the line, and the strobes are compared with
//                hand-computed bytes and latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_8n1;

    localparam int c_CPB = 16;

    logic clk;
    logic rst_n;

    uart_rx_8n1_if bus ();

    uart_rx_8n1 #(.CLKS_PER_BIT(c_CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     tag, obs, obs, exp, exp, cyc);
        end
    endtask

    // Strobe monitor. It samples 1 ns after each rising edge.
    int         n_valid    = 0;
    int         n_ferr     = 0;
    int         n_both     = 0;
    int         n_long     = 0;
    int         valid_cyc  = 0;
    logic [7:0] got_q[$];
    logic       prev_valid = 1'b0;
    logic       prev_ferr  = 1'b0;

    always @(posedge clk) begin
        #1;
        if (bus.valid === 1'b1) begin
            n_valid++;
            valid_cyc = cyc;
            got_q.push_back(bus.data);
        end
        if (bus.frame_err === 1'b1) n_ferr++;
        if (bus.valid === 1'b1 && bus.frame_err === 1'b1) n_both++;
        if ((bus.valid === 1'b1 && prev_valid) || (bus.frame_err === 1'b1 && prev_ferr)) n_long++;
        prev_valid = (bus.valid === 1'b1);
        prev_ferr  = (bus.frame_err === 1'b1);
    end

    task automatic clear_counts();
        n_valid = 0;
        n_ferr  = 0;
        got_q.delete();
    endtask

    // Drives one frame, starting at the next falling edge. The returned t0 is
    // the rising edge at which the first synchroniser flop captures the start
    // bit. The task returns on a falling edge, so frames can follow each other
    // with no gap.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, output int t0);
        @(negedge clk);
        t0     = cyc + 1;
        bus.rx = 1'b0;
        repeat (c_CPB - 1) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (c_CPB) @(negedge clk);
        end
        bus.rx = stop_bit;
        repeat (c_CPB) @(negedge clk);
    endtask

    int t0;
    int low_busy;
    int fall_cyc;
    int saw_busy;

    initial begin
        rst_n  = 1'b0;
        bus.rx = 1'b1;

        // Reset state, checked on every reset cycle.
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("rst_data",  int'(bus.data),      0);
            check("rst_valid", int'(bus.valid),     0);
            check("rst_ferr",  int'(bus.frame_err), 0);
            check("rst_busy",  int'(bus.busy),      0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("idle_busy", int'(bus.busy), 0);

        // Single byte A5.
        clear_counts();
        send_frame(8'hA5, 1'b1, t0);
        repeat (4) @(negedge clk);
        check("a5_count",   n_valid,              1);
        check("a5_data",    int'(bus.data),       'hA5);
        check("a5_latency", valid_cyc - t0,       155);
        check("a5_ferr",    n_ferr,               0);
        check("a5_busy",    int'(bus.busy),       0);

        // Back-to-back 00, FF, 3C with no idle time between frames.
        clear_counts();
        send_frame(8'h00, 1'b1, t0);
        send_frame(8'hFF, 1'b1, t0);
        send_frame(8'h3C, 1'b1, t0);
        repeat (6) @(negedge clk);
        check("b2b_count", n_valid, 3);
        check("b2b_ferr",  n_ferr,  0);
        if (got_q.size() == 3) begin
            check("b2b_byte0", int'(got_q[0]), 'h00);
            check("b2b_byte1", int'(got_q[1]), 'hFF);
            check("b2b_byte2", int'(got_q[2]), 'h3C);
        end else begin
            check("b2b_qsize", got_q.size(), 3);
        end
        check("b2b_latency", valid_cyc - t0, 155);
        check("b2b_data",    int'(bus.data), 'h3C);

        // Framing error: 55 sent with the stop bit low, then the line held low.
        clear_counts();
        send_frame(8'h55, 1'b0, t0);
        low_busy = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (bus.busy !== 1'b1) low_busy++;
            @(negedge clk);
        end
        check("fe_count",     n_ferr,          1);
        check("fe_valid",     n_valid,         0);
        check("fe_data_kept", int'(bus.data),  'h3C);
        check("fe_busy_held", low_busy,        0);
        bus.rx = 1'b1;
        repeat (5) @(negedge clk);
        check("fe_busy_rel",  int'(bus.busy),  0);
        repeat (200) @(negedge clk);
        check("fe_no_spur_v", n_valid,         0);
        check("fe_no_spur_f", n_ferr,          1);
        check("fe_idle_busy", int'(bus.busy),  0);

        // Glitch: line low for 4 clocks only.
        clear_counts();
        @(negedge clk);
        t0     = cyc + 1;
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        bus.rx   = 1'b1;
        saw_busy = 0;
        fall_cyc = -1;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.busy === 1'b1) saw_busy = 1;
            if (saw_busy == 1 && fall_cyc < 0 && bus.busy === 1'b0) fall_cyc = cyc;
        end
        check("gl_busy_seen", saw_busy, 1);
        check("gl_busy_fell", int'(fall_cyc >= 0 && (fall_cyc - t0) <= 11), 1);
        check("gl_no_valid",  n_valid, 0);
        check("gl_no_ferr",   n_ferr,  0);

        // Reset during data bit 4 of 81, then a clean 7E.
        clear_counts();
        @(negedge clk);
        bus.rx = 1'b0;
        repeat (c_CPB) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            bus.rx = (8'h81 >> i) & 8'h01;
            repeat ((i == 4) ? 8 : c_CPB) @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", int'(bus.busy), 0);
        check("mid_rst_data", int'(bus.data), 0);
        repeat (3) @(negedge clk);
        bus.rx = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("mid_abort_v", n_valid, 0);
        check("mid_abort_f", n_ferr,  0);
        send_frame(8'h7E, 1'b1, t0);
        repeat (4) @(negedge clk);
        check("mid_7e_count", n_valid,        1);
        check("mid_7e_data",  int'(bus.data), 'h7E);
        check("mid_7e_ferr",  n_ferr,         0);

        // Strobe properties over the whole run.
        check("strobe_overlap", n_both, 0);
        check("strobe_width",   n_long, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
